// File: rtl/native_ddr_pkg.sv
// Shared definitions for the native DDR app-interface responder.
//   APP_CMD_WR / APP_CMD_RD : legal app_cmd encodings
//   rsp_state_t             : responder FSM states
//   cmd_entry_t             : command-FIFO entry {cmd, word index}
// CMD_IDX_W is the word-index width carried in a command entry; the
// responder's MEM_AW must equal it.
package native_ddr_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam int CMD_IDX_W = 10;

  typedef enum logic {
    CALIB = 1'b0,
    READY = 1'b1
  } rsp_state_t;

  typedef struct packed {
    logic [2:0]           cmd;
    logic [CMD_IDX_W-1:0] idx;
  } cmd_entry_t;

endpackage

// File: rtl/native_ddr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clock, rst (async, active-high)
//   push, din   : write side; a push while full is ignored
//   pop         : read side; a pop while empty is ignored
//   dout        : head entry, valid whenever empty is low
//   full, empty : registered-pointer status
// A pushed entry becomes visible at dout on the cycle after the push.
module native_ddr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/native_ddr_app_responder.sv
// Memory-backed responder for the native DDR app interface. Stands in for
// the DDR controller on the far side of the AXI4-to-native bridge.
// Ports:
//   clock, rst (async, active-high)
//   app_addr/app_cmd/app_en/app_rdy          : command channel
//   app_wdf_data/mask/wren/end, app_wdf_rdy  : write-data channel
//   app_rd_data/valid/end                    : read-data channel (no backpressure)
//   init_calib_complete                      : high once calibration delay elapsed
//   cmd_err                                  : sticky, an illegal command retired
// Optional feature: define NATIVE_DDR_RDY_THROTTLE_EN to gate app_rdy and
// app_wdf_rdy with a free-running 16-bit LFSR (backpressure stress).
//
// Handshakes: a command transfers on a cycle where app_en && app_rdy, a write
// beat where app_wdf_wren && app_wdf_rdy. The ready signals depend only on
// registered state, never on app_en / app_wdf_wren. Read beats are one-cycle
// pulses that the initiator must take.
module native_ddr_app_responder
  import native_ddr_pkg::*;
#(
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 256,
  parameter int MEM_AW         = CMD_IDX_W,
  parameter int ADDR_STEP_LOG2 = 3,
  parameter int CMD_DEPTH      = 16,
  parameter int WDF_DEPTH      = 16,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 64
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete,
  output logic                    cmd_err
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int WDF_W  = DATA_WIDTH + MASK_W;
  localparam int CAL_W  = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam logic [CAL_W-1:0] CAL_ONE  = 1;
  localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CALIB_CYCLES - 1);

  // ---------------- FSM: calibration delay ----------------
  rsp_state_t       state, state_next;
  logic [CAL_W-1:0] cal_cnt, cal_cnt_next;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state   <= CALIB;
      cal_cnt <= '0;
    end else begin
      state   <= state_next;
      cal_cnt <= cal_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cal_cnt_next = cal_cnt;
    case (state)
      CALIB: begin
        if (cal_cnt == CAL_LAST) state_next = READY;
        else                     cal_cnt_next = cal_cnt + CAL_ONE;
      end
      READY:   state_next = READY;
      default: state_next = CALIB;
    endcase
  end

  assign init_calib_complete = (state == READY);

  // ---------------- Optional ready throttle ----------------
  logic cmd_gate;
  logic wdf_gate;
`ifdef NATIVE_DDR_RDY_THROTTLE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign cmd_gate = lfsr[0];
  assign wdf_gate = lfsr[1];
`else
  assign cmd_gate = 1'b1;
  assign wdf_gate = 1'b1;
`endif

  // ---------------- Command and write-data FIFOs ----------------
  cmd_entry_t                cmd_in, head;
  logic                      cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [WDF_W-1:0]          wdf_dout;
  logic [DATA_WIDTH-1:0]     wdf_data;
  logic [MASK_W-1:0]         wdf_mask;
  logic                      wdf_full, wdf_empty, wdf_push, wdf_pop;

  assign app_rdy     = init_calib_complete && !cmd_full && cmd_gate;
  assign app_wdf_rdy = init_calib_complete && !wdf_full && wdf_gate;
  assign cmd_push    = app_en && app_rdy;
  assign wdf_push    = app_wdf_wren && app_wdf_rdy;

  // Address bits above the RAM index are dropped, so addresses wrap.
  assign cmd_in.cmd = app_cmd;
  assign cmd_in.idx = app_addr[ADDR_STEP_LOG2 +: MEM_AW];

  native_ddr_sync_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (cmd_push),
    .din   (cmd_in),
    .pop   (cmd_pop),
    .dout  (head),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  native_ddr_sync_fifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (wdf_push),
    .din   ({app_wdf_data, app_wdf_mask}),
    .pop   (wdf_pop),
    .dout  (wdf_dout),
    .full  (wdf_full),
    .empty (wdf_empty)
  );

  assign {wdf_data, wdf_mask} = wdf_dout;

  // ---------------- Execution: one retirement per cycle ----------------
  logic head_wr, head_rd, wr_fire, rd_fire, ill_fire;

  assign head_wr  = (head.cmd == APP_CMD_WR);
  assign head_rd  = (head.cmd == APP_CMD_RD);
  // A write at the head waits for its data beat and blocks everything behind it.
  assign wr_fire  = !cmd_empty && head_wr && !wdf_empty;
  assign rd_fire  = !cmd_empty && head_rd;
  assign ill_fire = !cmd_empty && !head_wr && !head_rd;
  assign cmd_pop  = wr_fire || rd_fire || ill_fire;
  assign wdf_pop  = wr_fire;

  logic [DATA_WIDTH-1:0] ram [1 << MEM_AW];

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wdf_mask[b]) ram[head.idx][8*b +: 8] <= wdf_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) cmd_err <= 1'b0;
    else if (ill_fire) cmd_err <= 1'b1;
  end

  // ---------------- Read pipeline ----------------
  // Each stage's data only loads with a valid beat, so the last stage holds
  // the most recent beat while app_rd_data_valid is low.
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= rd_fire;
      if (rd_fire) pipe_data[0] <= ram[head.idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign app_rd_data       = pipe_data[RD_LATENCY-1];
  assign app_rd_data_valid = pipe_valid[RD_LATENCY-1];
  assign app_rd_data_end   = pipe_valid[RD_LATENCY-1];

  logic unused_bits;
  assign unused_bits = ^{app_wdf_end,
                         app_addr[ADDR_WIDTH-1:ADDR_STEP_LOG2+MEM_AW],
                         app_addr[ADDR_STEP_LOG2-1:0]};

endmodule

// File: tb/tb_native_ddr_app_responder.sv
// Self-checking bench for native_ddr_app_responder.
// A queue-based model tracks pending commands, pending write beats, RAM
// contents and scheduled read beats; a negedge process compares every DUT
// output against it each cycle. Directed sequences add literal expectations.
// Honors NATIVE_DDR_RDY_THROTTLE_EN (ready is then only bounded above).
module tb_native_ddr_app_responder;
  import native_ddr_pkg::*;

  localparam int DW = 256;
  localparam int MW = 32;
  localparam int RD_LAT = 4;
  localparam int CAL = 64;
  localparam int DEPTH = 16;
`ifdef NATIVE_DDR_RDY_THROTTLE_EN
  localparam int NPAIRS = 1000;
`else
  localparam int NPAIRS = 300;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic [26:0]   app_addr = '0;
  logic [2:0]    app_cmd = '0;
  logic          app_en = 1'b0;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data = '0;
  logic [MW-1:0] app_wdf_mask = '0;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_end = 1'b0;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          init_calib_complete;
  logic          cmd_err;

  always #5 clock = ~clock;

  native_ddr_app_responder dut (
    .clock               (clock),
    .rst                 (rst),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .cmd_err             (cmd_err)
  );

  // ---------------- counters / check helpers ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [2:0] cmd; int idx; } mcmd_t;
  typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; } mwdf_t;
  typedef struct { int due; logic [DW-1:0] data; bit known; } mrd_t;

  mcmd_t         cmd_q[$];
  mwdf_t         wdf_q[$];
  mrd_t          exp_q[$];
  logic [DW-1:0] mem [int];
  bit            m_err = 0;
  logic [DW-1:0] last_data = '0;
  bit            last_known = 1;
  int            calib = 0;
  bit            seen_rdy = 0;
  bit            seen_wdf_rdy = 0;

  mcmd_t         h;
  mwdf_t         w;
  logic [DW-1:0] word;

  always @(posedge clock) begin
    if (rst) begin
      cmd_q.delete();
      wdf_q.delete();
      exp_q.delete();
      m_err = 0;
      last_data = '0;
      last_known = 1;
      calib = 0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        last_data = exp_q[0].data;
        last_known = exp_q[0].known;
        void'(exp_q.pop_front());
      end
      if (cmd_q.size() > 0) begin
        h = cmd_q[0];
        if (h.cmd == APP_CMD_WR) begin
          if (wdf_q.size() > 0) begin
            w = wdf_q.pop_front();
            word = mem.exists(h.idx) ? mem[h.idx] : 'x;
            for (int b = 0; b < MW; b++)
              if (!w.mask[b]) word[8*b +: 8] = w.data[8*b +: 8];
            mem[h.idx] = word;
            void'(cmd_q.pop_front());
          end
        end else if (h.cmd == APP_CMD_RD) begin
          word = mem.exists(h.idx) ? mem[h.idx] : 'x;
          exp_q.push_back('{cyc + RD_LAT, word, !$isunknown(word)});
          void'(cmd_q.pop_front());
        end else begin
          m_err = 1;
          void'(cmd_q.pop_front());
        end
      end
      if (app_en && seen_rdy)
        cmd_q.push_back('{app_cmd, int'((app_addr >> 3) % 1024)});
      if (app_wdf_wren && seen_wdf_rdy)
        wdf_q.push_back('{app_wdf_data, app_wdf_mask});
      if (calib < CAL) calib++;
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  bit nom_rdy, nom_wdf, exp_v;

  always @(negedge clock) begin
    seen_rdy = app_rdy;
    seen_wdf_rdy = app_wdf_rdy;
    if (rst) begin
      check_bit("rst_app_rdy", app_rdy, 1'b0);
      check_bit("rst_wdf_rdy", app_wdf_rdy, 1'b0);
      check_bit("rst_rd_valid", app_rd_data_valid, 1'b0);
      check_bit("rst_rd_end", app_rd_data_end, 1'b0);
      check_bit("rst_calib", init_calib_complete, 1'b0);
      check_bit("rst_cmd_err", cmd_err, 1'b0);
      check("rst_rd_data", app_rd_data, '0);
    end else begin
      nom_rdy = (calib >= CAL) && (cmd_q.size() < DEPTH);
      nom_wdf = (calib >= CAL) && (wdf_q.size() < DEPTH);
`ifdef NATIVE_DDR_RDY_THROTTLE_EN
      check_bit("app_rdy_bound", app_rdy && !nom_rdy, 1'b0);
      check_bit("wdf_rdy_bound", app_wdf_rdy && !nom_wdf, 1'b0);
`else
      check_bit("app_rdy", app_rdy, nom_rdy);
      check_bit("app_wdf_rdy", app_wdf_rdy, nom_wdf);
`endif
      check_bit("init_calib", init_calib_complete, calib >= CAL);
      check_bit("cmd_err", cmd_err, m_err);
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check_bit("rd_valid", app_rd_data_valid, exp_v);
      check_bit("rd_end", app_rd_data_end, exp_v);
      if (exp_v) begin
        if (exp_q[0].known) check("rd_data", app_rd_data, exp_q[0].data);
      end else if (last_known) begin
        check("rd_hold", app_rd_data, last_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int k);
    repeat (k) begin @(posedge clock); #1; end
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [26:0] a, output int acc_cyc);
    int n = 0;
    bit acc = 0;
    acc_cyc = 0;
    app_en = 1; app_cmd = c; app_addr = a;
    while (!acc && n < 2000) begin
      @(negedge clock);
      acc = app_rdy;
      acc_cyc = cyc;
      @(posedge clock); #1;
      n++;
    end
    app_en = 0;
    check_bit("cmd_accept", acc, 1'b1);
  endtask

  task automatic send_wdf(input logic [DW-1:0] d, input logic [MW-1:0] m);
    int n = 0;
    bit acc = 0;
    app_wdf_wren = 1; app_wdf_end = 1; app_wdf_data = d; app_wdf_mask = m;
    while (!acc && n < 2000) begin
      @(negedge clock);
      acc = app_wdf_rdy;
      @(posedge clock); #1;
      n++;
    end
    app_wdf_wren = 0; app_wdf_end = 0;
    check_bit("wdf_accept", acc, 1'b1);
  endtask

  task automatic wait_rd(output logic [DW-1:0] d, output int vcyc);
    int n = 0;
    bit got = 0;
    d = '0; vcyc = 0;
    while (!got && n < 100) begin
      @(negedge clock);
      if (app_rd_data_valid) begin got = 1; d = app_rd_data; vcyc = cyc; end
      n++;
    end
    check_bit("rd_arrive", got, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic rand_word(output logic [DW-1:0] d);
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] d, d2, d3exp, d5;
  logic [DW-1:0] d4 [16];
  logic [DW-1:0] wdata [NPAIRS];
  logic [MW-1:0] wmask [NPAIRS];
  int            widx [NPAIRS];
  int            ridx [NPAIRS];
  int            ta, tv, n;
  bit            saw;

  initial begin
    #900000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    d2 = 256'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978_87969594_A5B4C3D2_E1F00112_2334ABCD;
    d3exp = {128'h0, {128{1'b1}}};
    repeat (4) @(posedge clock);
    #1 rst = 0;

    // 1. calibration delay
    n = 0;
    @(negedge clock);
    while (!init_calib_complete && n < 200) begin n++; @(negedge clock); end
    check("t1_calib_cycles", n, 64);
`ifndef NATIVE_DDR_RDY_THROTTLE_EN
    check_bit("t1_app_rdy", app_rdy, 1'b1);
    check_bit("t1_wdf_rdy", app_wdf_rdy, 1'b1);
`endif
    @(posedge clock); #1;

    // 2. write then read, full data, latency from accept
    send_cmd(APP_CMD_WR, 27'h40, ta);
    send_wdf(d2, '0);
    idle(3);
    send_cmd(APP_CMD_RD, 27'h40, ta);
    wait_rd(d, tv);
    check("t2_data", d, d2);
    check("t2_latency", tv - ta, 5);

    // 3. partial mask
    send_cmd(APP_CMD_WR, 27'h80, ta);
    send_wdf({DW{1'b1}}, '0);
    send_cmd(APP_CMD_WR, 27'h80, ta);
    send_wdf('0, 32'h0000_FFFF);
    send_cmd(APP_CMD_RD, 27'h80, ta);
    wait_rd(d, tv);
    check("t3_partial", d, d3exp);

    // 4. data-late stall fills the command FIFO
    idle(5);
    for (int i = 0; i < 16; i++) send_cmd(APP_CMD_WR, 27'((16 + i) * 8), ta);
    @(negedge clock);
    check_bit("t4_full_rdy", app_rdy, 1'b0);
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) begin
      rand_word(d4[i]);
      send_wdf(d4[i], '0);
    end
    for (int i = 0; i < 16; i++) begin
      send_cmd(APP_CMD_RD, 27'((16 + i) * 8), ta);
      wait_rd(d, tv);
      check($sformatf("t4_rd%0d", i), d, d4[i]);
    end

    // 5. address wrap and illegal command
    rand_word(d5);
    send_cmd(APP_CMD_WR, 27'h2000, ta);
    send_wdf(d5, '0);
    send_cmd(APP_CMD_RD, 27'h0, ta);
    wait_rd(d, tv);
    check("t5_wrap", d, d5);
    send_cmd(3'b010, 27'h0, ta);
    saw = 0;
    repeat (10) begin @(negedge clock); if (app_rd_data_valid) saw = 1; end
    check_bit("t5_no_beat", saw, 1'b0);
    check_bit("t5_cmd_err", cmd_err, 1'b1);
    @(posedge clock); #1;

    // 6. reset with reads in flight
    send_cmd(APP_CMD_RD, 27'h40, ta);
    send_cmd(APP_CMD_RD, 27'h80, ta);
    send_cmd(APP_CMD_RD, 27'h0, ta);
    rst = 1;
    repeat (3) @(posedge clock);
    #1 rst = 0;
    n = 0; saw = 0;
    @(negedge clock);
    while (!init_calib_complete && n < 200) begin
      if (app_rd_data_valid) saw = 1;
      n++;
      @(negedge clock);
    end
    check_bit("t6_no_beat", saw, 1'b0);
    check("t6_recal_cycles", n, 64);
    check_bit("t6_cmd_err_clr", cmd_err, 1'b0);
`ifndef NATIVE_DDR_RDY_THROTTLE_EN
    check_bit("t6_app_rdy", app_rdy, 1'b1);
`endif
    @(posedge clock); #1;

    // 7. random write/read pairs over a 32-word window
    for (int i = 0; i < 32; i++) begin
      rand_word(d);
      send_cmd(APP_CMD_WR, 27'(i * 8), ta);
      send_wdf(d, '0);
    end
    for (int i = 0; i < NPAIRS; i++) begin
      widx[i] = $urandom_range(0, 31);
      ridx[i] = $urandom_range(0, 31);
      rand_word(wdata[i]);
      wmask[i] = ($urandom_range(0, 1) == 0) ? '0 : MW'($urandom());
    end
    fork
      begin
        for (int i = 0; i < NPAIRS; i++) begin
          logic [26:0] a;
          a = 27'($urandom());
          a[12:3] = 10'(widx[i]);
          send_cmd(APP_CMD_WR, a, ta);
          idle($urandom_range(0, 2));
          a = 27'($urandom());
          a[12:3] = 10'(ridx[i]);
          send_cmd(APP_CMD_RD, a, ta);
        end
      end
      begin
        for (int i = 0; i < NPAIRS; i++) begin
          idle($urandom_range(0, 3));
          send_wdf(wdata[i], wmask[i]);
        end
      end
    join
    idle(40);
    check_bit("t7_drained", (cmd_q.size() == 0) && (exp_q.size() == 0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
